// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue stage: MIPS decode to ALU op/operands behind a 2-entry skid buffer
// Optional operand forwarding from writeback when FORWARD_EN is defined.
module alu_issue_stage #(
   parameter int DATA_W       = 32,
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
`ifdef FORWARD_EN
   input  logic              wb_en,
   input  logic [4:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [4:0]        dest_reg,
   output logic              wr_en,
   output logic              illegal
);

   generate
      if (DATA_W != 32) begin : g_bad_width
         $error("alu_issue_stage supports DATA_W=32 only");
      end
   endgenerate

   typedef struct packed {
      logic [2:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [4:0]        dest;
      logic              wr;
      logic              ill;
   } bundle_t;

   bundle_t           dec, main_q, skid_q;
   logic              main_valid, skid_valid;
   logic              legal, push;
   logic [DATA_W-1:0] rs_v, rt_v, se_imm, ze_imm;

   always_comb begin
      rs_v = rs_data;
      rt_v = rt_data;
`ifdef FORWARD_EN
      if (wb_en && wb_reg != 5'd0 && wb_reg == instr[25:21]) rs_v = wb_data;
      if (wb_en && wb_reg != 5'd0 && wb_reg == instr[20:16]) rt_v = wb_data;
`endif
      se_imm   = {{16{instr[15]}}, instr[15:0]};
      ze_imm   = {16'h0000, instr[15:0]};
      legal    = 1'b1;
      dec      = '0;
      dec.a    = rs_v;
      dec.b    = rt_v;
      dec.dest = instr[20:16];
      case (instr[31:26])
         6'h00: begin
            dec.dest = instr[15:11];
            case (instr[5:0])
               6'h21:   dec.op = 3'd2;
               6'h23:   dec.op = 3'd3;
               6'h24:   dec.op = 3'd0;
               6'h25:   dec.op = 3'd1;
               6'h2B:   dec.op = 3'd4;
               default: legal  = 1'b0;
            endcase
         end
         6'h09: begin dec.op = 3'd2; dec.b = se_imm; end
         6'h0B: begin dec.op = 3'd4; dec.b = se_imm; end
         6'h0C: begin dec.op = 3'd0; dec.b = ze_imm; end
         6'h0D: begin dec.op = 3'd1; dec.b = ze_imm; end
         6'h0F: begin dec.op = 3'd1; dec.a = '0; dec.b = {instr[15:0], 16'h0000}; end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec.op   = 3'd0;
         dec.dest = 5'd0;
      end
      dec.ill = !legal;
      dec.wr  = legal && (dec.dest != 5'd0);
   end

   // Untrapped illegal words are consumed from decode but never enter the buffer.
   assign push     = in_valid && in_ready && (legal || ILLEGAL_TRAP);
   assign in_ready = !skid_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || out_ready) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (push) begin
            main_q     <= dec;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (push) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid = main_valid;
   assign alu_op    = main_q.op;
   assign alu_a     = main_q.a;
   assign alu_b     = main_q.b;
   assign dest_reg  = main_q.dest;
   assign wr_en     = main_q.wr;
   assign illegal   = main_q.ill;

endmodule
